nco_core: RTL and testbench
===========================

Name: nco_core

Overview:
- Downstream consumer of the NCO control FSM's nco_we/nco_en/nco_freq_step outputs.
- Holds a writable waveform look-up table (LUT) and streams LUT words into it during load.
- In run mode, drives a phase accumulator that reads the LUT and produces a registered sample stream.
- Returns nco_load_ready to the control FSM when a full-table load completes.

Parameters:
ADDR_W, 10, LUT address width; depth = 2**ADDR_W
DATA_W, 16, LUT word and sample width
PHASE_W, 20, phase accumulator width; must be >= ADDR_W and >= STEP_W
STEP_W, 14, frequency step width

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
nco_we_i  in  1  load request (level) from the control FSM
nco_en_i  in  1  run enable (level) from the control FSM
nco_freq_step_i  in  STEP_W  phase increment per cycle, unsigned
lut_wdata_i  in  DATA_W  LUT word to load
lut_wvalid_i  in  1  lut_wdata_i valid
lut_wready_o  out  1  core accepts a LUT word this cycle
nco_load_ready_o  out  1  full table written (level)
sample_o  out  DATA_W  output sample
sample_valid_o  out  1  sample_o valid this cycle

Behaviour:
- Reset (async, active-high): state IDLE; phase = 0; waddr = 0; all outputs 0. LUT contents are not reset.
- States: IDLE, LOAD, DONE, RUN.
- IDLE:
  - nco_we_i=1 -> LOAD; clears phase and waddr. nco_we_i has priority over nco_en_i.
  - Else nco_en_i=1 -> RUN.
- LOAD:
  - lut_wready_o=1.
  - Each cycle with lut_wvalid_i & lut_wready_o: LUT[waddr] <= lut_wdata_i; waddr++.
  - Write at waddr = 2**ADDR_W-1 -> DONE, and lut_wready_o drops next cycle.
  - nco_we_i falls before the table is full (abort) -> IDLE. Partial contents are kept, nco_load_ready_o is never asserted, and waddr restarts at 0 on the next LOAD.
- DONE:
  - nco_load_ready_o=1 (registered), lut_wready_o=0.
  - Held until nco_we_i=0, then -> IDLE with nco_load_ready_o=0 next cycle.
  - The control FSM drops we one cycle after seeing ready; the level hold tolerates that latency.
- RUN:
  - Each cycle: phase <= phase + zero-extended nco_freq_step_i, mod 2**PHASE_W (silent wrap).
  - Read address = phase[PHASE_W-1 -: ADDR_W] taken from the current phase register, then a synchronous LUT read, then the sample_o register.
  - Phase value to sample_o latency: 2 cycles.
  - sample_valid_o is nco_en_i-in-RUN delayed 2 cycles.
  - nco_freq_step_i=0 -> phase holds; samples stay valid and repeat.
  - nco_en_i=0 -> IDLE. Phase is retained (not cleared); the pipeline drains and valid falls 2 cycles later.
  - nco_we_i=1 -> LOAD immediately. In-flight samples are flushed (sample_valid_o=0 from the next cycle); phase is cleared.
- Simultaneous nco_we_i and nco_en_i in any state: load path wins.
- lut_wready_o=0 outside LOAD. lut_wvalid_i is ignored outside LOAD.
- The LUT is single-port. Load and run are mutually exclusive, so there is no read/write collision.
- Reset mid-LOAD or mid-RUN: immediate return to reset values. LUT keeps written words.
- sample_o holds its last value when not valid (no zeroing), except after reset (0).

Test Plan:
- Full load: we=1, stream 1024 words LUT[i]=i with wvalid always high -> 1024 handshakes, nco_load_ready_o=1 the cycle after the 1024th write, wready=0. Drop we -> ready=0 next cycle.
- Backpressured load: wvalid toggles 1/0 -> exactly 1024 writes, ready after the last; readback during run matches ramp.
- Run, step=1024 (one address/cycle): en=1 after ramp load -> sample_valid_o rises 2 cycles later; sample_o = 0,1,2,...,1023,0,1,... wraps at address 1023.
- Step=256 -> each sample repeats 4 times. Step=4096 -> samples 0,4,8,... Step=0 -> constant sample, valid stays high.
- Abort/priority:
  - we falls after 500 writes -> IDLE, no ready; the next load starts at address 0.
  - we=1 and en=1 simultaneously in IDLE -> LOAD entered, no samples.
  - we=1 during RUN -> valid=0 next cycle, phase cleared.
- Reset mid-run (rst high for 1 cycle at sample 300) -> all outputs 0 immediately. Re-run with step=1024 -> samples restart at 0 (LUT content intact).

Source files
------------

// File: rtl/nco_core.sv
// Numerically controlled oscillator core: writable waveform LUT loaded by a
// streaming handshake, then read by a phase accumulator to produce samples.
module nco_core #(
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 16,
  parameter int PHASE_W = 20,
  parameter int STEP_W  = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              nco_we_i,
  input  logic              nco_en_i,
  input  logic [STEP_W-1:0] nco_freq_step_i,
  input  logic [DATA_W-1:0] lut_wdata_i,
  input  logic              lut_wvalid_i,
  output logic              lut_wready_o,
  output logic              nco_load_ready_o,
  output logic [DATA_W-1:0] sample_o,
  output logic              sample_valid_o
);

  typedef enum logic [1:0] {IDLE, LOAD, DONE, RUN} state_t;

  state_t              state, state_nxt;
  logic [PHASE_W-1:0]  phase;
  logic [ADDR_W-1:0]   waddr;
  logic [DATA_W-1:0]   lut [2**ADDR_W];
  logic [DATA_W-1:0]   rd_data;
  logic                rd_valid;
  logic                wr_fire;
  logic                run_adv;

  assign wr_fire      = (state == LOAD) && lut_wvalid_i;
  assign run_adv      = (state == RUN) && nco_en_i && !nco_we_i;
  assign lut_wready_o = (state == LOAD);

  // Load request always wins over run enable.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (nco_we_i)      state_nxt = LOAD;
        else if (nco_en_i) state_nxt = RUN;
      end
      LOAD: begin
        if (!nco_we_i)                     state_nxt = IDLE;
        else if (wr_fire && waddr == '1)   state_nxt = DONE;
      end
      DONE: begin
        if (!nco_we_i) state_nxt = IDLE;
      end
      RUN: begin
        if (nco_we_i)      state_nxt = LOAD;
        else if (!nco_en_i) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      phase            <= '0;
      waddr            <= '0;
      nco_load_ready_o <= 1'b0;
      rd_valid         <= 1'b0;
      sample_valid_o   <= 1'b0;
      sample_o         <= '0;
    end else begin
      state            <= state_nxt;
      nco_load_ready_o <= (state_nxt == DONE);
      if (state != LOAD && state_nxt == LOAD) begin
        phase <= '0;
        waddr <= '0;
      end else if (wr_fire) begin
        waddr <= waddr + 1'b1;
      end else if (run_adv) begin
        phase <= phase + PHASE_W'(nco_freq_step_i);
      end
      // A load request flushes anything still in the read pipeline.
      rd_valid       <= run_adv;
      sample_valid_o <= rd_valid && !nco_we_i;
      if (rd_valid && !nco_we_i) sample_o <= rd_data;
    end
  end

  // Single-port table: writes only in LOAD, reads only in RUN.
  always_ff @(posedge clk) begin
    if (wr_fire)          lut[waddr] <= lut_wdata_i;
    else if (state == RUN) rd_data   <= lut[phase[PHASE_W-1 -: ADDR_W]];
  end

endmodule

// File: tb/tb_nco_core.sv
// Randomized self-checking bench for nco_core against a table/phase reference model.
module tb_nco_core;

  localparam int ADDR_W  = 10;
  localparam int DATA_W  = 16;
  localparam int PHASE_W = 20;
  localparam int STEP_W  = 14;
  localparam int DEPTH   = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              nco_we_i;
  logic              nco_en_i;
  logic [STEP_W-1:0] nco_freq_step_i;
  logic [DATA_W-1:0] lut_wdata_i;
  logic              lut_wvalid_i;
  logic              lut_wready_o;
  logic              nco_load_ready_o;
  logic [DATA_W-1:0] sample_o;
  logic              sample_valid_o;

  nco_core #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .PHASE_W(PHASE_W),
    .STEP_W (STEP_W)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .nco_we_i        (nco_we_i),
    .nco_en_i        (nco_en_i),
    .nco_freq_step_i (nco_freq_step_i),
    .lut_wdata_i     (lut_wdata_i),
    .lut_wvalid_i    (lut_wvalid_i),
    .lut_wready_o    (lut_wready_o),
    .nco_load_ready_o(nco_load_ready_o),
    .sample_o        (sample_o),
    .sample_valid_o  (sample_valid_o)
  );

  always #5 clk = ~clk;

  int unsigned       n_checks = 0;
  int unsigned       n_fail   = 0;
  logic [DATA_W-1:0] ref_lut [DEPTH];
  int unsigned       phase_m  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Table word addressed by the top ADDR_W bits of a phase value (mod 2**PHASE_W).
  function automatic logic [31:0] exp_sample(input int unsigned p);
    int unsigned idx;
    idx = (p % (1 << PHASE_W)) / (1 << (PHASE_W - ADDR_W));
    return 32'(ref_lut[idx]);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input int unsigned n_words, input bit backp, input bit ramp,
                         input bit en_hold);
    int unsigned cnt = 0;
    int unsigned cyc = 0;
    nco_we_i = 1'b1;
    nco_en_i = en_hold;
    tick();
    phase_m = 0;
    while (cnt < n_words && cyc < 20000) begin
      lut_wvalid_i = backp ? ($urandom_range(0, 1) == 1) : 1'b1;
      lut_wdata_i  = ramp ? DATA_W'(cnt) : DATA_W'($urandom);
      check("load_wready", 32'(lut_wready_o), 32'd1);
      check("load_ready_low", 32'(nco_load_ready_o), 32'd0);
      check("load_no_valid", 32'(sample_valid_o), 32'd0);
      tick();
      if (lut_wvalid_i) begin
        ref_lut[cnt] = lut_wdata_i;
        cnt++;
      end
      cyc++;
    end
    lut_wvalid_i = 1'b0;
    check("load_count", cnt, n_words);
    if (n_words == DEPTH) begin
      check("done_ready", 32'(nco_load_ready_o), 32'd1);
      check("done_wready", 32'(lut_wready_o), 32'd0);
      tick();
      check("done_ready_hold", 32'(nco_load_ready_o), 32'd1);
      nco_we_i = 1'b0;
      nco_en_i = 1'b0;
      tick();
      check("done_ready_drop", 32'(nco_load_ready_o), 32'd0);
      check("idle_wready", 32'(lut_wready_o), 32'd0);
    end else begin
      nco_we_i = 1'b0;
      nco_en_i = 1'b0;
      tick();
      check("abort_ready", 32'(nco_load_ready_o), 32'd0);
      check("abort_wready", 32'(lut_wready_o), 32'd0);
    end
  endtask

  // mode 0: stop by dropping en; 1: interrupt with a load request; 2: reset mid-run.
  task automatic run_check(input int unsigned step, input int unsigned n, input int mode);
    int unsigned p0;
    logic [31:0] last;
    p0 = phase_m;
    nco_freq_step_i = STEP_W'(step);
    nco_en_i = 1'b1;
    tick();
    check("run_lat1", 32'(sample_valid_o), 32'd0);
    tick();
    check("run_lat2", 32'(sample_valid_o), 32'd0);
    for (int unsigned k = 0; k < n; k++) begin
      tick();
      check("run_valid", 32'(sample_valid_o), 32'd1);
      check("run_sample", 32'(sample_o), exp_sample(p0 + k * step));
    end
    phase_m = (p0 + (n + 1) * step) % (1 << PHASE_W);
    if (mode == 0) begin
      nco_en_i = 1'b0;
      tick();
      last = exp_sample(p0 + n * step);
      check("drain_valid", 32'(sample_valid_o), 32'd1);
      check("drain_sample", 32'(sample_o), last);
      tick();
      check("drain_valid_low", 32'(sample_valid_o), 32'd0);
      check("drain_sample_hold", 32'(sample_o), last);
    end else if (mode == 1) begin
      nco_we_i = 1'b1;
      tick();
      check("flush_valid", 32'(sample_valid_o), 32'd0);
      check("flush_wready", 32'(lut_wready_o), 32'd1);
      nco_en_i = 1'b0;
      phase_m  = 0;
    end else begin
      rst = 1'b1;
      #1;
      check("rst_sample", 32'(sample_o), 32'd0);
      check("rst_valid", 32'(sample_valid_o), 32'd0);
      check("rst_wready", 32'(lut_wready_o), 32'd0);
      check("rst_ready", 32'(nco_load_ready_o), 32'd0);
      nco_en_i = 1'b0;
      @(posedge clk);
      #1;
      rst     = 1'b0;
      phase_m = 0;
      tick();
    end
  endtask

  initial begin
    rst             = 1'b1;
    nco_we_i        = 1'b0;
    nco_en_i        = 1'b0;
    nco_freq_step_i = '0;
    lut_wdata_i     = '0;
    lut_wvalid_i    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_sample", 32'(sample_o), 32'd0);
    check("reset_valid", 32'(sample_valid_o), 32'd0);
    check("reset_wready", 32'(lut_wready_o), 32'd0);
    check("reset_ready", 32'(nco_load_ready_o), 32'd0);
    rst = 1'b0;
    tick();

    do_load(DEPTH, 1'b0, 1'b1, 1'b0);
    run_check(1024, 1100, 0);
    run_check(256, 40, 0);
    run_check(4096, 40, 0);
    run_check(0, 20, 0);
    run_check($urandom_range(1, (1 << STEP_W) - 1), 60, 0);

    do_load(DEPTH, 1'b1, 1'b0, 1'b0);
    run_check(1024, 1024, 0);

    do_load(500, 1'b0, 1'b0, 1'b0);
    run_check(1024, 1024, 0);

    do_load(DEPTH, 1'b1, 1'b1, 1'b1);
    run_check(1024, 200, 1);
    do_load(DEPTH, 1'b0, 1'b1, 1'b0);
    run_check(1024, 300, 2);
    run_check(1024, 1030, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
